// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write side, read side, status and error pulses.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with thresholds, read-valid strobe and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (default: 1-cycle registered read).
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL exceeds DEPTH");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc_c, rd_acc_c;
`ifndef SYNC_FIFO_FWFT_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
`endif

  // Accept decisions and next state, all from registered occupancy.
  always_comb begin
    wr_acc_c    = bus.wr_en & ~full_q;
    rd_acc_c    = bus.rd_en & ~empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = bus.wr_en & full_q;
    underflow_d = bus.rd_en & empty_q;
`ifndef SYNC_FIFO_FWFT_EN
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
`endif

    if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
`ifndef SYNC_FIFO_FWFT_EN
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
`endif
    end

    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered copies of the count decode, so they track count_q exactly.
    full_d         = (count_d == CNT_W'(DEPTH));
    empty_d        = (count_d == CNT_W'(0));
    almost_full_d  = (count_d >= CNT_W'(AF_LEVEL));
    almost_empty_d = (count_d <= CNT_W'(AE_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
`ifndef SYNC_FIFO_FWFT_EN
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
`endif
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= bus.wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.rd_valid = ~empty_q;
`else
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (registered-read build, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_param;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic clk = 1'b0;
  logic rst;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_if ();

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of stored words plus the last popped word.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_rd_data;
  bit            m_valid, m_ovf, m_unf;

  typedef struct {
    bit          wr;
    logic [7:0]  wd;
    bit          rd;
    int          count;
    bit          full;
    bit          empty;
    bit          af;
    bit          ae;
    bit          valid;
    logic [7:0]  data;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_rd_data = '0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, settle 1 time unit past it.
  task automatic drive(input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit was_full, was_empty;
    @(negedge clk);
    bus_if.wr_en   = wr;
    bus_if.wr_data = wd;
    bus_if.rd_en   = rd;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_ovf   = wr && was_full;
    m_unf   = rd && was_empty;
    m_valid = 1'b0;
    if (rd && !was_empty) begin
      m_rd_data = mq.pop_front();
      m_valid   = 1'b1;
    end
    if (wr && !was_full) mq.push_back(wd);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, " count"}, 32'(bus_if.count), 32'(n));
    chk({tag, " full"}, 32'(bus_if.full), 32'(n == DEPTH));
    chk({tag, " empty"}, 32'(bus_if.empty), 32'(n == 0));
    chk({tag, " almost_full"}, 32'(bus_if.almost_full), 32'(n >= AF));
    chk({tag, " almost_empty"}, 32'(bus_if.almost_empty), 32'(n <= AE));
    chk({tag, " rd_valid"}, 32'(bus_if.rd_valid), 32'(m_valid));
    chk({tag, " rd_data"}, 32'(bus_if.rd_data), 32'(m_rd_data));
    chk({tag, " overflow"}, 32'(bus_if.overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(bus_if.underflow), 32'(m_unf));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " count"}, 32'(bus_if.count), 32'd0);
    chk({tag, " empty"}, 32'(bus_if.empty), 32'd1);
    chk({tag, " full"}, 32'(bus_if.full), 32'd0);
    chk({tag, " almost_empty"}, 32'(bus_if.almost_empty), 32'd1);
    chk({tag, " almost_full"}, 32'(bus_if.almost_full), 32'd0);
    chk({tag, " rd_valid"}, 32'(bus_if.rd_valid), 32'd0);
    chk({tag, " rd_data"}, 32'(bus_if.rd_data), 32'd0);
    chk({tag, " overflow"}, 32'(bus_if.overflow), 32'd0);
    chk({tag, " underflow"}, 32'(bus_if.underflow), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int c;
    int wr_pct, rd_pct;
    bit wr, rd;

    // Directed table: fill past full, drain, then read while empty.
    for (int i = 0; i < 8; i++) begin
      c = i + 1;
      tv.push_back('{1'b1, 8'(8'h11 + i), 1'b0, c, c == 8, 1'b0, c >= AF, c <= AE,
                     1'b0, 8'h00, 1'b0, 1'b0});
    end
    tv.push_back('{1'b1, 8'hAA, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tv.push_back('{1'b0, 8'h00, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      c = 7 - i;
      tv.push_back('{1'b0, 8'h00, 1'b1, c, 1'b0, c == 0, c >= AF, c <= AE,
                     1'b1, 8'(8'h11 + i), 1'b0, 1'b0});
    end
    tv.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h18, 1'b0, 1'b1});
    tv.push_back('{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h18, 1'b0, 1'b0});

    rst = 1'b1;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.wr_data = '0;
    model_clear();
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check_reset_outputs("idle");

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].wr, tv[i].wd, tv[i].rd);
      chk($sformatf("vec%0d count", i), 32'(bus_if.count), 32'(tv[i].count));
      chk($sformatf("vec%0d full", i), 32'(bus_if.full), 32'(tv[i].full));
      chk($sformatf("vec%0d empty", i), 32'(bus_if.empty), 32'(tv[i].empty));
      chk($sformatf("vec%0d almost_full", i), 32'(bus_if.almost_full), 32'(tv[i].af));
      chk($sformatf("vec%0d almost_empty", i), 32'(bus_if.almost_empty), 32'(tv[i].ae));
      chk($sformatf("vec%0d rd_valid", i), 32'(bus_if.rd_valid), 32'(tv[i].valid));
      chk($sformatf("vec%0d rd_data", i), 32'(bus_if.rd_data), 32'(tv[i].data));
      chk($sformatf("vec%0d overflow", i), 32'(bus_if.overflow), 32'(tv[i].ovf));
      chk($sformatf("vec%0d underflow", i), 32'(bus_if.underflow), 32'(tv[i].unf));
    end

    // Simultaneous push/pop at count 3 across pointer wrap.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    check_model("pre_sim");
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1);
      check_model($sformatf("sim%0d", i));
      chk($sformatf("sim%0d count3", i), 32'(bus_if.count), 32'd3);
      chk($sformatf("sim%0d order", i), 32'(bus_if.rd_data),
          32'((i < 3) ? (8'h30 + i) : (8'h40 + i - 3)));
    end

    // Asynchronous reset mid-stream at count 5 with a non-zero rd_data.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    drive(1'b0, '0, 1'b1);
    check_model("pre_rst");
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive(1'b1, 8'h5A, 1'b0);
    check_model("post_rst_wr");
    drive(1'b0, '0, 1'b1);
    check_model("post_rst_rd");
    chk("post_rst data", 32'(bus_if.rd_data), 32'h5A);
    chk("post_rst valid", 32'(bus_if.rd_valid), 32'd1);

    // Randomised traffic against the queue model, with phases of varying pressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin wr_pct = 75; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 75; end
        default: begin wr_pct = 55; rd_pct = 55; end
      endcase
      wr = ($urandom_range(0, 99) < wr_pct);
      rd = ($urandom_range(0, 99) < rd_pct);
      drive(wr, 8'($urandom), rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
